// File: rtl/parity_pkg.sv
// rtl/parity_pkg.sv - shared types and constants for the framed nibble parity checker
package parity_pkg;

  localparam int NIB_W     = 4;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    S_DATA   = 2'd0,
    S_CHECK  = 2'd1,
    S_REPORT = 2'd2
  } state_e;

endpackage

// File: rtl/nibble_xnor4.sv
// rtl/nibble_xnor4.sv - combinational 4-input XNOR (even-parity detect)
module nibble_xnor4 (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic y
);

  assign y = ~(a ^ b ^ c ^ d);

endmodule

// File: rtl/nibble_parity_checker.sv
// rtl/nibble_parity_checker.sv - framed row/column parity checker with frame and error counters
module nibble_parity_checker
  import parity_pkg::*;
#(
  parameter int FRAME_LEN = 4,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NIB_W-1:0]     in_nibble,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [FRAME_LEN-1:0] out_row_mask,
  output logic                 out_col_err,
  output logic [CNT_W-1:0]     frame_cnt,
  output logic [CNT_W-1:0]     err_cnt
);

  localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

  state_e                 state_q, state_d;
  logic [3:0]             idx_q, idx_d;
  logic [NIB_W-1:0]       acc_q, acc_d;
  logic [FRAME_LEN-1:0]   mask_q, mask_d;
  logic [FRAME_LEN-1:0]   row_mask_q, row_mask_d;
  logic                   col_err_q, col_err_d;
  logic [CNT_W-1:0]       frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]       err_cnt_q, err_cnt_d;
  logic                   row_bit;
  logic                   accept;

  nibble_xnor4 u_xnor4 (
    .a (in_nibble[3]),
    .b (in_nibble[2]),
    .c (in_nibble[1]),
    .d (in_nibble[0]),
    .y (row_bit)
  );

  assign in_ready     = (state_q != S_REPORT);
  assign out_valid    = (state_q == S_REPORT);
  assign accept       = in_valid && in_ready;
  assign out_row_mask = row_mask_q;
  assign out_col_err  = col_err_q;
  assign frame_cnt    = frame_cnt_q;
  assign err_cnt      = err_cnt_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    mask_d      = mask_q;
    row_mask_d  = row_mask_q;
    col_err_d   = col_err_q;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;

    case (state_q)
      S_DATA: begin
        if (accept) begin
          acc_d = acc_q ^ in_nibble;
          for (int i = 0; i < FRAME_LEN; i++) begin
            if (idx_q == 4'(i)) mask_d[i] = row_bit;
          end
          idx_d = idx_q + 4'd1;
          if (idx_q == LAST_IDX) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (accept) begin
          col_err_d  = (acc_q != in_nibble);
          row_mask_d = mask_q;
          state_d    = S_REPORT;
        end
      end
      S_REPORT: begin
        // Result registers are left as-is after the handshake; only the
        // per-frame working state is cleared for the next frame.
        if (out_ready) begin
          frame_cnt_d = frame_cnt_q + 1'b1;
          if (col_err_q && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
          acc_d   = '0;
          idx_d   = '0;
          mask_d  = '0;
          state_d = S_DATA;
        end
      end
      default: state_d = S_DATA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_DATA;
      idx_q       <= '0;
      acc_q       <= '0;
      mask_q      <= '0;
      row_mask_q  <= '0;
      col_err_q   <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      mask_q      <= mask_d;
      row_mask_q  <= row_mask_d;
      col_err_q   <= col_err_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

endmodule
